// File: rtl/clarvi_soc_out_pulse_pio.sv
// Avalon-MM output PIO for the CLARVI SoC: data register, atomic set/clear,
// and a hardware one-shot pulse generator that forces masked bits high.
module clarvi_soc_out_pulse_pio #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_LEN  = 3'd2;
  localparam logic [2:0] ADDR_TRIG = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [31:0]           rd_next;

  logic                  wr;
  logic                  fire;
  logic                  busy;
  logic [DATA_WIDTH-1:0] wr_bits;
  logic [CNT_WIDTH-1:0]  wr_len;
  logic                  unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wr_bits      = writedata[DATA_WIDTH-1:0];
  assign wr_len       = writedata[CNT_WIDTH-1:0];
  assign unused_wdata = ^writedata[31:CNT_WIDTH];
  assign busy         = (state_q == ACTIVE);
  // A trigger or retrigger needs a non-zero mask and a non-zero length.
  assign fire         = wr && (address == ADDR_TRIG) && (wr_bits != '0) && (len_q != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      len_q  <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA: data_q <= wr_bits;
        ADDR_LEN:  len_q  <= wr_len;
        ADDR_SET:  data_q <= data_q | wr_bits;
        ADDR_CLR:  data_q <= data_q & ~wr_bits;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire) begin
            state_q <= ACTIVE;
            mask_q  <= wr_bits;
            count_q <= len_q;
          end
        end
        ACTIVE: begin
          if (fire) begin
            mask_q  <= mask_q | wr_bits;
            count_q <= len_q;
          end else begin
            // count is never below 1 while active, so this cannot wrap.
            count_q <= count_q - CNT_WIDTH'(1);
            if (count_q == CNT_WIDTH'(1)) begin
              state_q <= IDLE;
              mask_q  <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: default every combinational output first so no path infers a latch.
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next[DATA_WIDTH-1:0] = data_q;
      ADDR_LEN:  rd_next[CNT_WIDTH-1:0]  = len_q;
      ADDR_TRIG: begin
        rd_next[31]             = busy;
        rd_next[DATA_WIDTH-1:0] = mask_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign out_port = data_q | (busy ? mask_q : '0);

endmodule

// File: tb/tb_clarvi_soc_out_pulse_pio.sv
// Self-checking bench for clarvi_soc_out_pulse_pio: directed vector table,
// hand-written pulse sequences, and random traffic against an end-time model.
module tb_clarvi_soc_out_pulse_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_pass   = 0;
  int n_checks = 0;

  clarvi_soc_out_pulse_pio #(
    .DATA_WIDTH (8),
    .RESET_VALUE(8'h00),
    .CNT_WIDTH  (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the pulse is described by the edge index where it ends,
  // busy after edge e means e < m_end.
  logic [7:0]  m_data;
  logic [15:0] m_len;
  logic [7:0]  m_mask;
  longint      m_e;
  longint      m_end;

  task automatic m_reset();
    m_data = 8'h00; m_len = 16'h0; m_mask = 8'h00; m_e = 0; m_end = 0;
  endtask

  function automatic logic m_busy();
    return m_e < m_end;
  endfunction

  function automatic logic [7:0] m_out();
    return m_data | (m_busy() ? m_mask : 8'h00);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'h0, m_data};
      3'd2: return {16'h0, m_len};
      3'd3: return m_busy() ? {1'b1, 23'h0, m_mask} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_edge(input logic wr, input logic [2:0] a, input logic [31:0] wd);
    logic was_busy;
    was_busy = m_busy();
    m_e++;
    if (wr) begin
      case (a)
        3'd0: m_data = wd[7:0];
        3'd2: m_len  = wd[15:0];
        3'd3: if (wd[7:0] != 8'h00 && m_len != 16'h0) begin
                m_mask = was_busy ? (m_mask | wd[7:0]) : wd[7:0];
                m_end  = m_e + longint'(m_len);
              end
        3'd4: m_data = m_data | wd[7:0];
        3'd5: m_data = m_data & ~wd[7:0];
        default: ;
      endcase
    end
  endtask

  // One bus cycle: drive, capture on the edge, compare 1 time unit later.
  task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    exp_rd = m_read(a);
    @(posedge clk);
    m_edge(cs && !wn, a, wd);
    #1;
    check("model out_port", {24'h0, out_port}, {24'h0, m_out()});
    check("model readdata", readdata, exp_rd);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
    step(1'b1, 1'b0, a, wd);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    step(1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    check("reset out_port", {24'h0, out_port}, 32'h0);
    check("reset readdata", readdata, 32'h0);
    m_reset();
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0000_00A5, 8'hA5, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 3'd0, 32'h0,         8'hA5, 32'h0000_00A5};
    vecs[2]  = '{1'b1, 1'b0, 3'd0, 32'hFFFF_FF0F, 8'h0F, 32'h0000_00A5};
    vecs[3]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0030, 8'h3F, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0003, 8'h3C, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 3'd0, 32'h0000_00FF, 8'h3C, 32'h0000_003C};
    vecs[6]  = '{1'b1, 1'b0, 3'd1, 32'h0000_00FF, 8'h3C, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 3'd1, 32'h0,         8'h3C, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 3'd2, 32'h0001_2345, 8'h3C, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 3'd2, 32'h0,         8'h3C, 32'h0000_2345};
    vecs[10] = '{1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF, 8'h3C, 32'h0};

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
    m_reset();
    #12;
    check("reset out_port", {24'h0, out_port}, 32'h0);
    check("reset readdata", readdata, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd);
      check($sformatf("vec%0d out_port", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
      check($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
    end

    // Basic pulse: LEN=5, mask 0x81, high for exactly five cycles.
    wr_reg(3'd0, 32'h0);
    wr_reg(3'd2, 32'd5);
    wr_reg(3'd3, 32'h81);
    check("pulse start", {24'h0, out_port}, 32'h81);
    for (int i = 1; i <= 5; i++) begin
      rd_reg(3'd3);
      check($sformatf("pulse T+%0d out", i), {24'h0, out_port}, (i < 5) ? 32'h81 : 32'h0);
      check($sformatf("pulse T+%0d busy", i), readdata, 32'h8000_0081);
    end
    rd_reg(3'd3);
    check("pulse after busy", readdata, 32'h0);

    // Retrigger: LEN=10, 0x01 at T, 0x02 at T+4, end at T+14.
    wr_reg(3'd2, 32'd10);
    wr_reg(3'd3, 32'h01);
    for (int i = 1; i <= 3; i++) begin
      rd_reg(3'd0);
      check($sformatf("retrig T+%0d out", i), {24'h0, out_port}, 32'h01);
    end
    wr_reg(3'd3, 32'h02);
    check("retrig T+4 out", {24'h0, out_port}, 32'h03);
    for (int i = 5; i <= 14; i++) begin
      rd_reg(3'd0);
      check($sformatf("retrig T+%0d out", i), {24'h0, out_port}, (i < 14) ? 32'h03 : 32'h0);
    end

    // Ignored triggers.
    wr_reg(3'd2, 32'd0);
    wr_reg(3'd3, 32'hFF);
    check("len0 trig out", {24'h0, out_port}, 32'h0);
    rd_reg(3'd3);
    check("len0 trig busy", readdata, 32'h0);
    wr_reg(3'd2, 32'd3);
    wr_reg(3'd3, 32'h00);
    rd_reg(3'd3);
    check("mask0 trig busy", readdata, 32'h0);
    check("mask0 trig out", {24'h0, out_port}, 32'h0);

    // Reset in the middle of a long pulse.
    wr_reg(3'd2, 32'd100);
    wr_reg(3'd3, 32'hFF);
    for (int i = 0; i < 3; i++) rd_reg(3'd3);
    check("long pulse out", {24'h0, out_port}, 32'hFF);
    async_reset();
    rd_reg(3'd2);
    check("len after reset", readdata, 32'h0);
    rd_reg(3'd3);
    check("busy after reset", readdata, 32'h0);

    // Maximum length pulse, with a LEN change and DATA writes while active.
    wr_reg(3'd2, 32'h0000_FFFF);
    wr_reg(3'd3, 32'h10);
    wr_reg(3'd2, 32'd2);
    wr_reg(3'd0, 32'h01);
    for (int i = 0; i < 20; i++) rd_reg(3'd3);
    check("max len busy", readdata, 32'h8000_0010);
    check("max len out", {24'h0, out_port}, 32'h11);
    async_reset();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic        cs, wn;
      logic [2:0]  a;
      logic [31:0] wd;
      cs = ($urandom_range(0, 3) != 0);
      wn = $urandom_range(0, 1) != 0;
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd2) wd = 32'($urandom_range(0, 12)) | (wd & 32'hFFFF_0000);
      if (a == 3'd3 && $urandom_range(0, 3) == 0) wd = wd & 32'hFFFF_FF00;
      step(cs, wn, a, wd);
      if (i == 750) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
